// File: rtl/parity_pkg.sv
// Shared definitions for the parity generate/check pair: receiver FSM states,
// data width and the reference parity function.
package parity_pkg;

  parameter int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_t;

  // Expected parity bit for a byte: ^data for even parity, ~^data for odd.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Bus bundle of the parity-frame receiver.
// PARITY_RX_ERRCNT_EN adds the error-counter clear input and count output.
interface parity_frame_rx_if;
  import parity_pkg::*;

  logic              en;
  logic              sin;
  logic              sin_v;
  logic [DATA_W-1:0] d;
  logic              dv;
  logic              perr;
  logic              ferr;
  logic              busy;
`ifdef PARITY_RX_ERRCNT_EN
  logic              errcnt_clr;
  logic [7:0]        errcnt;
`endif

`ifdef PARITY_RX_ERRCNT_EN
  modport master (output en, sin, sin_v, errcnt_clr,
                  input  d, dv, perr, ferr, busy, errcnt);
  modport slave  (input  en, sin, sin_v, errcnt_clr,
                  output d, dv, perr, ferr, busy, errcnt);
`else
  modport master (output en, sin, sin_v,
                  input  d, dv, perr, ferr, busy);
  modport slave  (input  en, sin, sin_v,
                  output d, dv, perr, ferr, busy);
`endif

endinterface

// File: rtl/parity_err_counter.sv
// Saturating 8-bit error counter; clear wins over increment.
module parity_err_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q, count_d;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (inc_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial parity-frame receiver: start, 8 data bits LSB first, parity, stop.
// Define PARITY_RX_ERRCNT_EN to add the saturating error counter.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int unsigned ODD_PARITY = 0
) (
  input logic              clk,
  input logic              rst,
  parity_frame_rx_if.slave bus
);

  rx_state_t         state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pb_q, pb_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              dv_q, dv_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              strobe;

  assign strobe = bus.en & bus.sin_v;

  // Next-state and completion outputs; state only moves on a consumed bit.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    pb_d     = pb_q;
    d_d      = d_q;
    dv_d     = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (!bus.en && (state_q != StIdle)) begin
      // Dropping enable mid-frame abandons the frame without a dv.
      state_d = StIdle;
    end else if (strobe) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.sin) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          // Shift in at the MSB so the LSB-first stream ends up in order.
          shreg_d  = {bus.sin, shreg_q[DATA_W-1:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          pb_d    = bus.sin;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          d_d     = shreg_q;
          dv_d    = 1'b1;
          perr_d  = pb_q ^ calc_parity(shreg_q, ODD_PARITY != 0);
          ferr_d  = ~bus.sin;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bitcnt_q <= 3'd0;
      shreg_q  <= '0;
      pb_q     <= 1'b0;
      d_q      <= '0;
      dv_q     <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      pb_q     <= pb_d;
      d_q      <= d_d;
      dv_q     <= dv_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.dv   = dv_q;
  assign bus.perr = perr_q;
  assign bus.ferr = ferr_q;
  assign bus.busy = (state_q != StIdle);

`ifdef PARITY_RX_ERRCNT_EN
  parity_err_counter u_err_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.errcnt_clr),
    .inc_i   (dv_q & (perr_q | ferr_q)),
    .count_o (bus.errcnt)
  );
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: an even- and an odd-parity instance
// receive the same stream; each has its own queue of expected frames.
module tb_parity_frame_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_frame_rx_if bus_e ();
  parity_frame_rx_if bus_o ();

  parity_frame_rx #(.ODD_PARITY(0)) u_even (.clk(clk), .rst(rst), .bus(bus_e));
  parity_frame_rx #(.ODD_PARITY(1)) u_odd  (.clk(clk), .rst(rst), .bus(bus_o));

  exp_t q [2][$];
  int   mon_pass = 0;
  int   mon_total = 0;
  int   dir_pass = 0;
  int   dir_total = 0;

  // Monitor-side comparison.
  task automatic mchk(input string name, input logic [7:0] act, input logic [7:0] req);
    mon_total++;
    if (act === req) mon_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // Stimulus-side comparison.
  task automatic dchk(input string name, input logic [7:0] act, input logic [7:0] req);
    dir_total++;
    if (act === req) dir_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  task automatic mon_one(input int idx, input logic dv, input logic [7:0] d,
                         input logic perr, input logic ferr);
    exp_t e;
    if (dv) begin
      if (q[idx].size() == 0) begin
        mchk($sformatf("unexpected_dv[%0d]", idx), 8'd1, 8'd0);
      end else begin
        e = q[idx].pop_front();
        mchk($sformatf("d[%0d]", idx), d, e.d);
        mchk($sformatf("perr[%0d]", idx), {7'd0, perr}, {7'd0, e.perr});
        mchk($sformatf("ferr[%0d]", idx), {7'd0, ferr}, {7'd0, e.ferr});
      end
    end else begin
      mchk($sformatf("flags_idle[%0d]", idx), {6'd0, perr, ferr}, 8'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one(0, bus_e.dv, bus_e.d, bus_e.perr, bus_e.ferr);
      mon_one(1, bus_o.dv, bus_o.d, bus_o.perr, bus_o.ferr);
    end
  end

  task automatic drive(input logic en, input logic sin, input logic sin_v);
    bus_e.en = en;  bus_e.sin = sin;  bus_e.sin_v = sin_v;
    bus_o.en = en;  bus_o.sin = sin;  bus_o.sin_v = sin_v;
  endtask

  // One strobed bit after 'gap' idle cycles; returns 1 time unit past the consuming edge.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    drive(1'b1, b, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, b, 1'b0);
  endtask

  // Full frame; expected results for both instances queued up front.
  task automatic send_frame(input logic [7:0] data, input logic pb, input logic stop,
                            input int maxgap);
    logic ones_odd;
    exp_t e;
    ones_odd = ($countones(data) % 2) == 1;
    e.d = data;
    e.ferr = ~stop;
    e.perr = (pb != ones_odd);
    q[0].push_back(e);
    e.perr = (pb != !ones_odd);
    q[1].push_back(e);
    send_bit(1'b0, $urandom_range(0, maxgap));
    for (int i = 0; i < 8; i++) send_bit(data[i], $urandom_range(0, maxgap));
    send_bit(pb, $urandom_range(0, maxgap));
    send_bit(stop, $urandom_range(0, maxgap));
  endtask

  task automatic set_clr(input logic v);
`ifdef PARITY_RX_ERRCNT_EN
    bus_e.errcnt_clr = v;
    bus_o.errcnt_clr = v;
`else
    if (v) $display("note: no error counter in this build");
`endif
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0);
    set_clr(1'b0);
    #1;
    dchk("rst_d", bus_e.d, 8'h00);
    dchk("rst_dv", {7'd0, bus_e.dv}, 8'd0);
    dchk("rst_busy", {7'd0, bus_e.busy}, 8'd0);
    dchk("rst_flags", {6'd0, bus_e.perr, bus_e.ferr}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x4B pb=0: even good, odd parity error.
    send_frame(8'h4B, 1'b0, 1'b1, 0);
    // 0x4B pb=1: odd good, even parity error.
    send_frame(8'h4B, 1'b1, 1'b1, 0);
    // 0xFF with stop 0: framing error on both.
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    // Random gaps, then back-to-back 0x01 and 0xA5.
    send_frame(8'h4B, 1'b0, 1'b1, 3);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    dchk("b2b_busy_in_dv_cycle", {7'd0, bus_e.busy}, 8'd0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    @(posedge clk);
    #1;

    // Enable dropped after the parity bit.
    send_bit(1'b0, 0);
    dchk("busy_after_start", {7'd0, bus_e.busy}, 8'd1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    drive(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    dchk("en_abort_busy", {7'd0, bus_e.busy}, 8'd0);
    dchk("en_abort_d", bus_e.d, 8'hA5);
    drive(1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset after the 4th data bit.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    dchk("pre_rst_busy", {7'd0, bus_e.busy}, 8'd1);
    rst = 1'b1;
    #1;
    dchk("rst_abort_busy", {7'd0, bus_e.busy}, 8'd0);
    dchk("rst_abort_d", bus_e.d, 8'h00);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef PARITY_RX_ERRCNT_EN
    send_frame(8'h4B, 1'b1, 1'b1, 0);
    @(posedge clk);
    #1;
    dchk("errcnt_one", bus_e.errcnt, 8'd1);
    for (int n = 0; n < 260; n++) send_frame(8'h4B, 1'b1, 1'b1, 0);
    @(posedge clk);
    #1;
    dchk("errcnt_sat", bus_e.errcnt, 8'd255);
    send_frame(8'h4B, 1'b1, 1'b1, 0);
    set_clr(1'b1);
    @(posedge clk);
    #1;
    set_clr(1'b0);
    dchk("errcnt_clr_wins", bus_e.errcnt, 8'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    dchk("q_even_drained", 8'(q[0].size()), 8'd0);
    dchk("q_odd_drained", 8'(q[1].size()), 8'd0);
    $display("%0d/%0d checks passed", mon_pass + dir_pass, mon_total + dir_total);
    $finish;
  end

endmodule
